cordic_iter: RTL and testbench
==============================

# cordic_iter

Iterative, multi-mode CORDIC engine: the parametrised successor to the fixed-configuration CORDIC core. It adds per-transaction rotation/vectoring mode selection and full-quadrant input coverage. It adds valid/ready backpressure on both sides and a transaction tag, and it time-multiplexes NUM_ITER micro-rotations over a configurable number of hardware stages. It sits between the sample front-end and the downstream DSP consumers, accepting one transaction at a time.

## Interface
- DATA_WIDTH, 16, signed width of i_x/i_y/i_z and o_z
- NUM_ITER, 12, total micro-rotations per transaction; must be a multiple of ITER_PER_CYCLE
- ITER_PER_CYCLE, 3, micro-rotation stages instantiated and applied per clock
- TAG_WIDTH, 4, width of pass-through transaction tag
- i_clk  in  1  clock; one clock; the only clock domain
- i_rst  in  1  reset; synchronous, active-high
- i_vld  in  1  input transaction valid
- o_rdy  out  1  engine can accept (high only in IDLE)
- i_mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0)
- i_tag  in  TAG_WIDTH  returned unchanged on o_tag
- i_x, i_y  in  DATA_WIDTH  signed vector
- i_z  in  DATA_WIDTH  signed binary angle, 2^(DATA_WIDTH-1) ≙ π
- o_vld  out  1  result valid, held until accepted
- i_rdy  in  1  downstream accepts result
- o_tag  out  TAG_WIDTH  tag of the result
- o_x, o_y  out  DATA_WIDTH+2  signed result, 2 guard bits for gain growth
- o_z  out  DATA_WIDTH  residual/accumulated angle

## Operation
- FSM states: IDLE, BUSY, (SCALE when CORDIC_GAIN_COMP_EN), DONE.
- IDLE: o_rdy=1. On i_vld: load registers with pre-rotated operands, clear pass counter, set state to BUSY.
- Pre-rotation, rotation mode: if |z| > π/2, negate x and y, and set z -= π·sign(z). This gives full ±π coverage.
- Pre-rotation, vectoring mode: if x < 0, negate x and y, and set z = π·sign(y) (y≥0 counts as +). Otherwise z = 0. The input i_z is ignored in vectoring mode.
- BUSY: each cycle applies iterations i = pass·ITER_PER_CYCLE … +ITER_PER_CYCLE-1 combinationally, then registers the result.
- Micro-rotation: d = sign(z) in rotation mode, d = -sign(y) in vectoring mode, with sign(0) = +. x' = x − d·(y>>>i), y' = y + d·(x>>>i), z' = z − d·atan(2^-i).
- Shifts are arithmetic. Internal x/y use DATA_WIDTH+2 bits. z wraps modulo 2^DATA_WIDTH.
- After NUM_ITER/ITER_PER_CYCLE passes, go to DONE (or SCALE first, when gain compensation is compiled in).
- DONE: o_vld=1 with all outputs stable. Leave to IDLE on i_rdy=1.
- i_rst=1: state returns to IDLE and any in-flight transaction is discarded without output. The reset has priority over every handshake.
- Reset values: o_vld=0, o_rdy=0 during the reset cycle (1 on the following IDLE cycle), o_x=o_y=o_z=0, o_tag=0.

## Timing
- Let P = NUM_ITER/ITER_PER_CYCLE. With accept in cycle T, o_vld rises in cycle T+P+1, or T+P+2 with CORDIC_GAIN_COMP_EN.
- The earliest next accept is one cycle after the output handshake. Initiation interval is ≥ P+2 cycles (P+3 with gain compensation).
- i_mode, i_tag, i_x, i_y and i_z are sampled only in the accept cycle. Input changes at any other time have no effect.
- With i_rdy held low, o_vld and all outputs stay constant indefinitely.
- Holding i_vld high in DONE does not cause an accept, because o_rdy=0.

## Configuration
- CORDIC_GAIN_COMP_EN defined: a SCALE state multiplies x and y by 1/K ≈ 0.607253 using a fixed shift-add sequence, error ≤ 2 LSB. This adds one cycle of latency, and results have unity gain.
- Macro undefined: there is no SCALE state, and outputs carry the CORDIC gain K ≈ 1.64676.

## Structure
- Shared package cordic_pkg holds:
  - the state enum
  - the mode constants
  - the atan(2^-i) constant table as binary angles, 32 entries, truncated to DATA_WIDTH
  - the 1/K shift-add constants
  - the binary-angle constants PI and HALF_PI
- Sub-module cordic_micro_rot: one combinational micro-rotation, with x, y, z, mode and iteration index in and x', y', z' out. It is instantiated ITER_PER_CYCLE times in a chain.

## Test plan
All cases use DATA_WIDTH=16, NUM_ITER=12, ITER_PER_CYCLE=3, with compensation off unless noted.
- Rotation x=10000, y=0, z=0 accepted at T -> o_vld at T+5, o_x≈16468±4, o_y≈0±4, o_z≈0±8.
- Vectoring x=3000, y=4000 -> o_x≈8234±4, o_y≈0±4, o_z≈9672±8 (atan 4/3).
- Rotation x=10000, y=0, z=0x6000 (3π/4), with CORDIC_GAIN_COMP_EN -> o_vld at T+6, o_x≈−7071±6, o_y≈7071±6.
- Vectoring x=−5000, y=0 -> o_x≈8234±4, o_z≈0x7FFF/0x8000 (±π).
- Backpressure: i_rdy=0 for 10 cycles after o_vld -> outputs and o_tag stable, o_rdy=0, a second i_vld is not accepted. Then i_rdy=1 -> o_vld=0 next cycle and o_rdy=1.
- i_rst pulsed in cycle T+2 mid-BUSY -> no o_vld ever appears for that tag, outputs are 0, and o_rdy=1 in the cycle after reset.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC types and constants (FSM states, modes, atan table, 1/K shift-add terms, binary angles)
package cordic_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, SCALE, DONE} state_t;
  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;
  localparam logic [31:0] PI = 32'h8000_0000;
  localparam logic [31:0] HALF_PI = 32'h4000_0000;
  // atan(2^-i) as 32-bit binary angles; users keep the top DATA_WIDTH bits
  localparam logic [31:0] ATAN_TAB [32] = '{
    32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517C,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A2F, 32'h0000_0517,
    32'h0000_028B, 32'h0000_0145, 32'h0000_00A2, 32'h0000_0051,
    32'h0000_0028, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000
  };
  // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 + 2^-14 + 2^-16
  localparam int SCALE_TERMS = 7;
  localparam int SCALE_SH [SCALE_TERMS] = '{1, 3, 6, 9, 12, 14, 16};
  localparam logic [SCALE_TERMS-1:0] SCALE_NEG = 7'b0011100;
  function automatic logic signed [63:0] scale_inv_k(input logic signed [63:0] v);
    logic signed [63:0] acc;
    logic signed [63:0] t;
    acc = '0;
    for (int j = 0; j < SCALE_TERMS; j++) begin
      t = (v <<< 16) >>> SCALE_SH[j];
      acc = SCALE_NEG[j] ? acc - t : acc + t;
    end
    return (acc + 64'sd32768) >>> 16;
  endfunction
endpackage

// File: rtl/cordic_micro_rot.sv
// cordic_micro_rot: one combinational CORDIC micro-rotation for iteration index iter
module cordic_micro_rot
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH+1:0] x,
  input  logic [DATA_WIDTH+1:0] y,
  input  logic [DATA_WIDTH-1:0] z,
  input  logic                  mode,
  input  logic [4:0]            iter,
  output logic [DATA_WIDTH+1:0] nx,
  output logic [DATA_WIDTH+1:0] ny,
  output logic [DATA_WIDTH-1:0] nz
);
  logic signed [DATA_WIDTH+1:0] xs, ys;
  logic [DATA_WIDTH-1:0] a;
  logic neg;
  assign xs = $signed(x) >>> iter;
  assign ys = $signed(y) >>> iter;
  assign a = DATA_WIDTH'(ATAN_TAB[iter] >> (32 - DATA_WIDTH));
  // neg means d = -1; sign(0) counts as positive
  assign neg = (mode == MODE_VEC) ? ~y[DATA_WIDTH+1] : z[DATA_WIDTH-1];
  assign nx = neg ? x + ys : x - ys;
  assign ny = neg ? y - xs : y + xs;
  assign nz = neg ? z + a : z - a;
endmodule

// File: rtl/cordic_iter.sv
// cordic_iter: iterative rotation/vectoring CORDIC with valid/ready and tag pass-through
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain K.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_ITER       = 12,
  parameter int ITER_PER_CYCLE = 3,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic                  i_mode,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [DATA_WIDTH-1:0] i_x,
  input  logic [DATA_WIDTH-1:0] i_y,
  input  logic [DATA_WIDTH-1:0] i_z,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [DATA_WIDTH+1:0] o_x,
  output logic [DATA_WIDTH+1:0] o_y,
  output logic [DATA_WIDTH-1:0] o_z
);
  localparam int XW = DATA_WIDTH + 2;
  localparam int P = NUM_ITER / ITER_PER_CYCLE;
  localparam int PW = $clog2(P + 1);
  localparam logic [PW-1:0] LAST = PW'(P - 1);
  localparam logic [DATA_WIDTH-1:0] PI_B = PI[31 -: DATA_WIDTH];
  localparam logic signed [DATA_WIDTH-1:0] HALF_B = HALF_PI[31 -: DATA_WIDTH];
  state_t state;
  logic [PW-1:0] pass_r;
  logic mode_r;
  logic signed [XW-1:0] x_r, y_r;
  logic [DATA_WIDTH-1:0] z_r;
  logic signed [XW-1:0] ext_x, ext_y, pre_x, pre_y;
  logic [DATA_WIDTH-1:0] pre_z;
  logic flip;
  assign ext_x = {{2{i_x[DATA_WIDTH-1]}}, i_x};
  assign ext_y = {{2{i_y[DATA_WIDTH-1]}}, i_y};
  assign flip = (i_mode == MODE_VEC) ? i_x[DATA_WIDTH-1]
              : ($signed(i_z) > HALF_B || $signed(i_z) < -HALF_B);
  assign pre_x = flip ? -ext_x : ext_x;
  assign pre_y = flip ? -ext_y : ext_y;
  // a shift by +/-pi is a top-bit flip in modulo-2pi binary angles
  assign pre_z = (i_mode == MODE_VEC) ? (flip ? PI_B : '0) : (flip ? i_z ^ PI_B : i_z);
  logic [XW-1:0] cx [ITER_PER_CYCLE+1];
  logic [XW-1:0] cy [ITER_PER_CYCLE+1];
  logic [DATA_WIDTH-1:0] cz [ITER_PER_CYCLE+1];
  assign cx[0] = x_r;
  assign cy[0] = y_r;
  assign cz[0] = z_r;
  for (genvar k = 0; k < ITER_PER_CYCLE; k++) begin : g_rot
    cordic_micro_rot #(.DATA_WIDTH(DATA_WIDTH)) u_rot (
      .x(cx[k]), .y(cy[k]), .z(cz[k]), .mode(mode_r),
      .iter(5'(int'(pass_r) * ITER_PER_CYCLE + k)),
      .nx(cx[k+1]), .ny(cy[k+1]), .nz(cz[k+1])
    );
  end
`ifdef CORDIC_GAIN_COMP_EN
  logic signed [XW-1:0] sx, sy;
  assign sx = XW'(scale_inv_k(64'(x_r)));
  assign sy = XW'(scale_inv_k(64'(y_r)));
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      pass_r <= '0;
      mode_r <= MODE_ROT;
      x_r <= '0;
      y_r <= '0;
      z_r <= '0;
      o_tag <= '0;
      o_vld <= 1'b0;
      o_rdy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_rdy <= 1'b1;
          if (o_rdy && i_vld) begin
            x_r <= pre_x;
            y_r <= pre_y;
            z_r <= pre_z;
            mode_r <= i_mode;
            o_tag <= i_tag;
            pass_r <= '0;
            o_rdy <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          x_r <= cx[ITER_PER_CYCLE];
          y_r <= cy[ITER_PER_CYCLE];
          z_r <= cz[ITER_PER_CYCLE];
          pass_r <= pass_r + 1'b1;
          if (pass_r == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= SCALE;
`else
            state <= DONE;
            o_vld <= 1'b1;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        SCALE: begin
          x_r <= sx;
          y_r <= sy;
          state <= DONE;
          o_vld <= 1'b1;
        end
`endif
        DONE: begin
          if (i_rdy) begin
            o_vld <= 1'b0;
            o_rdy <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign o_x = x_r;
  assign o_y = y_r;
  assign o_z = z_r;
endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: randomized self-checking bench for cordic_iter against a trigonometric reference model
module tb_cordic_iter;
  localparam int DW = 16, NI = 12, IPC = 3, TW = 4, P = NI / IPC;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = P + 2;
`else
  localparam int LAT = P + 1;
`endif
  localparam real PI_R = 3.14159265358979;
  logic clk = 1'b0, rst = 1'b1, vld = 1'b0, mode = 1'b0, rdy_in = 1'b0;
  logic rdy_out, ovld;
  logic [TW-1:0] tag = '0, otag;
  logic [DW-1:0] x = '0, y = '0, z = '0, oz;
  logic [DW+1:0] ox, oy;
  int vectors = 0, errors = 0;
  real gain;

  always #5 clk = ~clk;

  cordic_iter #(.DATA_WIDTH(DW), .NUM_ITER(NI), .ITER_PER_CYCLE(IPC), .TAG_WIDTH(TW)) dut (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .o_rdy(rdy_out), .i_mode(mode), .i_tag(tag),
    .i_x(x), .i_y(y), .i_z(z), .o_vld(ovld), .i_rdy(rdy_in), .o_tag(otag),
    .o_x(ox), .o_y(oy), .o_z(oz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic real rabs(input real v);
    return v < 0.0 ? -v : v;
  endfunction

  function automatic real zerr(input real a, input real e);
    real d;
    d = a - e;
    while (d > 32768.0) d -= 65536.0;
    while (d < -32768.0) d += 65536.0;
    return rabs(d);
  endfunction

  // ideal CORDIC: true rotation by z (rotation) or polar conversion (vectoring), scaled by the gain
  function automatic void model(input logic m, input int xi, input int yi, input int zi,
                                output real ex, output real ey, output real ez);
    real th;
    int zs;
    zs = (zi >= 32768) ? zi - 65536 : zi;
    if (!m) begin
      th = real'(zs) * PI_R / 32768.0;
      ex = gain * (real'(xi) * $cos(th) - real'(yi) * $sin(th));
      ey = gain * (real'(xi) * $sin(th) + real'(yi) * $cos(th));
      ez = 0.0;
    end else begin
      ex = gain * $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
      ey = 0.0;
      ez = $atan2(real'(yi), real'(xi)) * 32768.0 / PI_R;
    end
  endfunction

  task automatic apply(input logic m, input logic [TW-1:0] t, input int xi, input int yi,
                       input int zi, output int lat);
    int n;
    n = 0;
    while (!rdy_out && n < 20) begin tick(); n++; end
    mode = m; tag = t; x = DW'(xi); y = DW'(yi); z = DW'(zi); vld = 1'b1;
    tick();
    vld = 1'b0; mode = ~m; tag = ~t; x = DW'($urandom); y = DW'($urandom); z = DW'($urandom);
    lat = 1;
    while (!ovld && lat <= 50) begin tick(); lat++; end
    if (!ovld) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++; if (ovld !== 1'b0 || rdy_out !== 1'b0) begin errors++; $display("FAIL reset_hs: vld=%b rdy=%b want 0 0", ovld, rdy_out); end
    vectors++; if (ox !== '0 || oy !== '0 || oz !== '0 || otag !== '0) begin errors++; $display("FAIL reset_out: x=%h y=%h z=%h tag=%h want 0", ox, oy, oz, otag); end
    rst = 1'b0;
    tick();
    vectors++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL reset_rdy: rdy=%b want 1", rdy_out); end
  endtask

  task automatic test_function();
    int dm [4] = '{0, 1, 1, 0};
    int dx [4] = '{10000, 3000, -5000, 10000};
    int dy [4] = '{0, 4000, 0, 0};
    int dz [4] = '{0, 0, 0, 24576};
    int xi, yi, zi, lat;
    logic m;
    logic [TW-1:0] t;
    real ex, ey, ez, mag, tol, ztol;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) begin
        m = dm[i][0]; xi = dx[i]; yi = dy[i]; zi = dz[i];
      end else begin
        m = 1'($urandom);
        do begin
          xi = int'($urandom_range(40000)) - 20000;
          yi = int'($urandom_range(40000)) - 20000;
        end while (xi * xi + yi * yi < 4000000);
        zi = int'($urandom_range(65535));
      end
      t = TW'($urandom);
      apply(m, t, xi, yi, zi, lat);
      model(m, xi, yi, zi, ex, ey, ez);
      mag = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
      tol = 12.0 + mag * gain / 512.0;
      ztol = m ? 20.0 + 100000.0 / mag : 16.0;
      vectors++; if (lat != LAT) begin errors++; $display("FAIL latency[%0d]: got %0d want %0d", i, lat, LAT); end
      vectors++; if (otag !== t || rdy_out !== 1'b0) begin errors++; $display("FAIL tag[%0d]: tag=%h rdy=%b want %h 0", i, otag, rdy_out, t); end
      vectors++; if (rabs(real'(int'($signed(ox))) - ex) > tol) begin errors++; $display("FAIL x[%0d] mode=%b: got %0d want %0.1f", i, m, $signed(ox), ex); end
      vectors++; if (rabs(real'(int'($signed(oy))) - ey) > tol) begin errors++; $display("FAIL y[%0d] mode=%b: got %0d want %0.1f", i, m, $signed(oy), ey); end
      vectors++; if (zerr(real'(int'($signed(oz))), ez) > ztol) begin errors++; $display("FAIL z[%0d] mode=%b: got %0d want %0.1f", i, m, $signed(oz), ez); end
      rdy_in = 1'b1;
      tick();
      rdy_in = 1'b0;
      vectors++; if (ovld !== 1'b0 || rdy_out !== 1'b1) begin errors++; $display("FAIL release[%0d]: vld=%b rdy=%b want 0 1", i, ovld, rdy_out); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    real ex, ey, ez;
    apply(1'b0, 4'h5, 8000, -3000, 16'h2000, lat);
    model(1'b0, 8000, -3000, 16'h2000, ex, ey, ez);
    vectors++; if (lat != LAT) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
    for (int k = 0; k < 10; k++) begin
      vectors++; if (ovld !== 1'b1 || rdy_out !== 1'b0 || otag !== 4'h5) begin errors++; $display("FAIL bp_hold[%0d]: vld=%b rdy=%b tag=%h want 1 0 5", k, ovld, rdy_out, otag); end
      vectors++; if (rabs(real'(int'($signed(ox))) - ex) > 40.0 || rabs(real'(int'($signed(oy))) - ey) > 40.0 || zerr(real'(int'($signed(oz))), ez) > 16.0) begin errors++; $display("FAIL bp_data[%0d]: x=%0d y=%0d z=%0d want %0.1f %0.1f %0.1f", k, $signed(ox), $signed(oy), $signed(oz), ex, ey, ez); end
      vld = 1'b1; tag = 4'hF; x = DW'($urandom); y = DW'($urandom); z = DW'($urandom); mode = 1'($urandom);
      tick();
    end
    vld = 1'b0;
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    vectors++; if (ovld !== 1'b0 || rdy_out !== 1'b1) begin errors++; $display("FAIL bp_release: vld=%b rdy=%b want 0 1", ovld, rdy_out); end
  endtask

  task automatic test_back_to_back();
    int lat;
    real ex, ey, ez;
    rdy_in = 1'b1;
    apply(1'b1, 4'h3, -7000, 2000, 0, lat);
    vectors++; if (lat != LAT || otag !== 4'h3) begin errors++; $display("FAIL b2b_first: lat=%0d tag=%h want %0d 3", lat, otag, LAT); end
    tick();
    vectors++; if (ovld !== 1'b0 || rdy_out !== 1'b1) begin errors++; $display("FAIL b2b_gap: vld=%b rdy=%b want 0 1", ovld, rdy_out); end
    apply(1'b0, 4'hC, -6000, 9000, 16'hB000, lat);
    model(1'b0, -6000, 9000, 16'hB000, ex, ey, ez);
    vectors++; if (lat != LAT || otag !== 4'hC) begin errors++; $display("FAIL b2b_second: lat=%0d tag=%h want %0d C", lat, otag, LAT); end
    vectors++; if (rabs(real'(int'($signed(ox))) - ex) > 50.0 || rabs(real'(int'($signed(oy))) - ey) > 50.0) begin errors++; $display("FAIL b2b_data: x=%0d y=%0d want %0.1f %0.1f", $signed(ox), $signed(oy), ex, ey); end
    tick();
    rdy_in = 1'b0;
    vectors++; if (ovld !== 1'b0 || rdy_out !== 1'b1) begin errors++; $display("FAIL b2b_end: vld=%b rdy=%b want 0 1", ovld, rdy_out); end
  endtask

  task automatic test_reset_mid_busy();
    int n;
    logic seen;
    n = 0;
    while (!rdy_out && n < 20) begin tick(); n++; end
    mode = 1'b0; tag = 4'hA; x = DW'(12000); y = DW'(5000); z = DW'(16'h1000); vld = 1'b1;
    tick();
    vld = 1'b0;
    vectors++; if (rdy_out !== 1'b0 || ovld !== 1'b0) begin errors++; $display("FAIL busy_hs: rdy=%b vld=%b want 0 0", rdy_out, ovld); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (ovld !== 1'b0 || rdy_out !== 1'b0) begin errors++; $display("FAIL midrst_hs: vld=%b rdy=%b want 0 0", ovld, rdy_out); end
    vectors++; if (ox !== '0 || oy !== '0 || oz !== '0 || otag !== '0) begin errors++; $display("FAIL midrst_out: x=%h y=%h z=%h tag=%h want 0", ox, oy, oz, otag); end
    tick();
    vectors++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL midrst_rdy: rdy=%b want 1", rdy_out); end
    seen = 1'b0;
    repeat (12) begin tick(); if (ovld) seen = 1'b1; end
    vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_novld: saw o_vld=%b want 0", seen); end
  endtask

  initial begin
    gain = 1.0;
`ifndef CORDIC_GAIN_COMP_EN
    for (int i = 0; i < NI; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`endif
    test_reset();
    test_function();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
